dram_ctrl: RTL and testbench

DRAM_CTRL -- requirements
Module: dram_ctrl

---
 rtl/dram_ctrl_if.sv | 43 ++++
 rtl/dram_ctrl.sv | 105 ++++++++++
 tb/tb_dram_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_ctrl_if.sv
// Bundle of command, write-data, read-return and DRAM pin signals for dram_ctrl.
// master = client plus DRAM device side, slave = controller side.
interface dram_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_len;

  logic              wd_valid;
  logic [DATA_W-1:0] wd_data;
  logic              wd_ready;

  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;

  modport master (
    output req_valid, req_we, req_addr, req_len,
    output wd_valid, wd_data,
    output mem_q,
    input  req_ready, wd_ready,
    input  rd_valid, rd_data, rd_last,
    input  mem_addr, mem_data, mem_we
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len,
    input  wd_valid, wd_data,
    input  mem_q,
    output req_ready, wd_ready,
    output rd_valid, rd_data, rd_last,
    output mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/dram_ctrl.sv
// Single-port DRAM burst controller; DRAM_CTRL_BURST_EN honours req_len, otherwise every command is one beat.
// First beat the cycle after accept, read data one cycle after issue; writes stall on wd_valid, reads have no backpressure.
module dram_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input logic        clk,
  input logic        rst_n,
  dram_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
  localparam logic [1:0] ST_READ   = 2'd2;
  localparam logic [1:0] ST_RDRAIN = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [4:0]        cmd_beats;
  logic              last_beat;

`ifdef DRAM_CTRL_BURST_EN
  assign cmd_beats = {1'b0, bus.req_len} + 5'd1;
`else
  logic unused_req_len;
  assign unused_req_len = ^bus.req_len;
  assign cmd_beats      = 5'd1;
`endif

  assign last_beat = (count_q == 5'd1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          count_d = cmd_beats;
          state_d = bus.req_we ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        // A missing write beat simply stalls; there is no timeout.
        if (bus.wd_valid) begin
          addr_d  = addr_q + ADDR_ONE;
          count_d = count_q - 5'd1;
          if (last_beat) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        // Each issue this cycle becomes a returned beat next cycle.
        rd_valid_d = 1'b1;
        rd_last_d  = last_beat;
        addr_d     = addr_q + ADDR_ONE;
        count_d    = count_q - 5'd1;
        if (last_beat) begin
          state_d = ST_RDRAIN;
        end
      end
      ST_RDRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.wd_ready  = (state_q == ST_WRITE);
  assign bus.mem_we    = (state_q == ST_WRITE) & bus.wd_valid;
  assign bus.mem_data  = (state_q == ST_WRITE) ? bus.wd_data : '0;
  assign bus.mem_addr  = addr_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_data   = bus.mem_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Self-checking bench for dram_ctrl: transaction-level reference model, per-cycle compare, directed and random traffic.
module tb_dram_ctrl;
  localparam int AW = 12;
  localparam int DW = 32;
`ifdef DRAM_CTRL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  dram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbeats(input logic [3:0] len);
    return BURST ? int'(len) + 1 : 1;
  endfunction

  function automatic logic [DW-1:0] pat(input int a);
    return 32'h5A00_0000 ^ (a * 32'h0001_0003);
  endfunction

  // DRAM device: registered read port, write on mem_we.
  logic [DW-1:0] dram    [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  always @(posedge clk) begin
    if (bus.mem_we) dram[bus.mem_addr] <= bus.mem_data;
    bus.mem_q <= dram[bus.mem_addr];
  end

  // Reference model: per-transaction schedule of what each cycle must show.
  typedef struct { int c; logic [DW-1:0] d; bit last; } rd_exp_t;
  rd_exp_t rdq[$];
  int m_ph = 0;                 // 0 idle, 1 write, 2 read busy
  int m_left = 0;
  logic [AW-1:0] m_addr = '0;
  int m_idle = 0;
  int m_rd_c = 0;
  int m_rd_n = 0;
  logic [AW-1:0] m_rd_a = '0;

  int acc_q[$];
  logic [DW-1:0] got_d[$];
  bit got_l[$];
  logic [AW-1:0] wr_a[$];

  always @(negedge clk) begin
    int n;
    logic [AW-1:0] a;
    rd_exp_t e;
    if (!rst_n) begin
      chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
      chk("rst_mem_we", 64'(bus.mem_we), 64'(0));
      chk("rst_wd_ready", 64'(bus.wd_ready), 64'(0));
      chk("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
      chk("rst_rd_last", 64'(bus.rd_last), 64'(0));
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
      chk("rst_mem_data", 64'(bus.mem_data), 64'(0));
      m_ph = 0;
      rdq.delete();
    end else begin
      chk("req_ready", 64'(bus.req_ready), 64'(m_ph == 0));
      chk("wd_ready", 64'(bus.wd_ready), 64'(m_ph == 1));
      chk("mem_we", 64'(bus.mem_we), 64'((m_ph == 1) && bus.wd_valid));
      if (m_ph == 1) begin
        chk("wr_addr", 64'(bus.mem_addr), 64'(m_addr));
        if (bus.wd_valid) chk("wr_data", 64'(bus.mem_data), 64'(bus.wd_data));
      end
      if (m_ph == 2 && cyc > m_rd_c && cyc <= m_rd_c + m_rd_n) begin
        a = m_rd_a + AW'(cyc - m_rd_c - 1);
        chk("rd_issue_addr", 64'(bus.mem_addr), 64'(a));
      end
      if (rdq.size() > 0 && rdq[0].c == cyc) begin
        e = rdq.pop_front();
        chk("rd_valid", 64'(bus.rd_valid), 64'(1));
        chk("rd_data", 64'(bus.rd_data), 64'(e.d));
        chk("rd_last", 64'(bus.rd_last), 64'(e.last));
      end else begin
        chk("rd_valid_idle", 64'(bus.rd_valid), 64'(0));
        chk("rd_last_idle", 64'(bus.rd_last), 64'(0));
      end
      if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
      if (bus.rd_valid) begin
        got_d.push_back(bus.rd_data);
        got_l.push_back(bus.rd_last);
      end
      if (bus.mem_we) wr_a.push_back(bus.mem_addr);
      // Advance the model to the next cycle.
      if (m_ph == 0) begin
        if (bus.req_valid) begin
          n = nbeats(bus.req_len);
          if (bus.req_we) begin
            m_ph = 1; m_left = n; m_addr = bus.req_addr;
          end else begin
            m_ph = 2; m_rd_c = cyc; m_rd_n = n; m_rd_a = bus.req_addr; m_idle = cyc + n + 2;
            for (int i = 0; i < n; i++) begin
              a = bus.req_addr + AW'(i);
              e.c = cyc + 2 + i; e.d = ref_mem[a]; e.last = (i == n - 1);
              rdq.push_back(e);
            end
          end
        end
      end else if (m_ph == 1) begin
        if (bus.wd_valid) begin
          ref_mem[m_addr] = bus.wd_data;
          m_addr = m_addr + AW'(1);
          m_left--;
          if (m_left == 0) m_ph = 0;
        end
      end else if (cyc + 1 >= m_idle) begin
        m_ph = 0;
      end
    end
  end

  task automatic cmd(input bit we, input logic [AW-1:0] a, input logic [3:0] len, output int acc);
    int k;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_len = len;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.req_ready && k < 100);
    acc = cyc;
    chk("cmd_accept", 64'(bus.req_ready), 64'(1));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wbeat(input logic [DW-1:0] d, input int gap);
    int k;
    bus.wd_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.wd_valid = 1'b1; bus.wd_data = d;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.wd_ready && k < 100);
    chk("wbeat_accept", 64'(bus.wd_ready), 64'(1));
    @(posedge clk); #1;
    bus.wd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int at);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.req_ready && k < 200);
    at = cyc;
    chk("idle_reached", 64'(bus.req_ready), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic wr_burst(input logic [AW-1:0] a, input logic [3:0] len, input logic [DW-1:0] base, input int gap);
    int acc;
    cmd(1'b1, a, len, acc);
    for (int i = 0; i < nbeats(len); i++) wbeat(base + DW'(i), (i == 0) ? 0 : gap);
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input logic [3:0] len, output int acc, output int idle);
    got_d.delete(); got_l.delete();
    cmd(1'b0, a, len, acc);
    wait_idle(idle);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, idle, nb, k;
    logic [AW-1:0] ea;
    for (int i = 0; i < 4096; i++) begin dram[i] = pat(i); ref_mem[i] = pat(i); end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wd_valid = 1'b0; bus.wd_data = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Single writes then single reads.
    for (int i = 0; i < 3; i++) wr_burst(AW'(i), 4'd0, DW'(i + 1), 0);
    for (int i = 0; i < 3; i++) begin
      rd_burst(AW'(i), 4'd0, acc, idle);
      chk("single_rd_count", 64'(got_d.size()), 64'(1));
      chk("single_rd_data", 64'(got_d[0]), 64'(i + 1));
      chk("single_rd_last", 64'(got_l[0]), 64'(1));
    end

    // Burst write/read at 0x010, return to idle timing.
    wr_burst(12'h010, 4'd3, 32'hA0, 0);
    rd_burst(12'h010, 4'd3, acc, idle);
    nb = nbeats(4'd3);
    chk("burst_idle_latency", 64'(idle - acc), 64'(nb + 2));
    chk("burst_rd_count", 64'(got_d.size()), 64'(nb));
    for (int i = 0; i < nb; i++) begin
      chk("burst_rd_data", 64'(got_d[i]), 64'(32'hA0 + i));
      chk("burst_rd_last", 64'(got_l[i]), 64'(i == nb - 1));
    end

    // Address wrap 0xFFE..0x001.
    wr_a.delete();
    wr_burst(12'hFFE, 4'd3, 32'hC0, 0);
    chk("wrap_wr_count", 64'(wr_a.size()), 64'(nb));
    for (int i = 0; i < nb; i++) begin
      ea = 12'hFFE;
      ea = ea + AW'(i);
      chk("wrap_wr_addr", 64'(wr_a[i]), 64'(ea));
    end
    rd_burst(12'hFFE, 4'd3, acc, idle);
    for (int i = 0; i < nb; i++) chk("wrap_rd_data", 64'(got_d[i]), 64'(32'hC0 + i));

    // Write stall between beats.
    wr_burst(12'h020, 4'd1, 32'hD0, 3);
    rd_burst(12'h020, 4'd1, acc, idle);
    for (int i = 0; i < nbeats(4'd1); i++) chk("stall_rd_data", 64'(got_d[i]), 64'(32'hD0 + i));

    // Reset in the second cycle of a len=7 write burst.
    cmd(1'b1, 12'h100, 4'd7, acc);
    wbeat(32'hB0, 0);
    bus.wd_valid = 1'b1; bus.wd_data = 32'hB1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_mem_we", 64'(bus.mem_we), 64'(0));
    chk("async_req_ready", 64'(bus.req_ready), 64'(1));
    chk("async_wd_ready", 64'(bus.wd_ready), 64'(0));
    chk("async_mem_addr", 64'(bus.mem_addr), 64'(0));
    bus.wd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rd_burst(12'h100, 4'd7, acc, idle);
    nb = nbeats(4'd7);
    chk("rst_rd_count", 64'(got_d.size()), 64'(nb));
    chk("rst_first_word", 64'(got_d[0]), 64'(32'hB0));
    for (int i = 1; i < nb; i++) chk("rst_unwritten", 64'(got_d[i]), 64'(pat(32'h100 + i)));

    // req_valid held through a read: second accept only once idle.
    acc_q.delete(); got_d.delete(); got_l.delete();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h010; bus.req_len = 4'd5;
    k = 0;
    for (int t = 0; t < 100 && k < 2; t++) begin
      @(negedge clk);
      if (bus.req_ready) k++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_idle(idle);
    nb = nbeats(4'd5);
    chk("hold_accepts", 64'(acc_q.size()), 64'(2));
    if (acc_q.size() == 2) chk("hold_accept_gap", 64'(acc_q[1] - acc_q[0]), 64'(nb + 2));
    chk("hold_rd_count", 64'(got_d.size()), 64'(2 * nb));
    if (got_d.size() > 0) chk("hold_rd_first", 64'(got_d[0]), 64'(32'hA0));

    // Random traffic against the model.
    for (int t = 0; t < 80; t++) begin
      logic [AW-1:0] ra;
      logic [3:0] rl;
      ra = ($urandom_range(0, 3) == 0) ? AW'(12'hFF0 + $urandom_range(0, 15)) : AW'($urandom_range(0, 4095));
      rl = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        cmd(1'b1, ra, rl, acc);
        for (int i = 0; i < nbeats(rl); i++) wbeat($urandom, $urandom_range(0, 2));
      end else begin
        rd_burst(ra, rl, acc, idle);
        chk("rand_rd_idle", 64'(idle - acc), 64'(nbeats(rl) + 2));
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    repeat (4) begin @(posedge clk); #1; end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
